// File: rtl/ifetch_unit.sv
// ifetch_unit: program counter, imem request/grant/response front end and in-order {pc, instr} FIFO toward decode.
// Latency: grant in N, rvalid in N+1, out_valid in N+2 (N+1 with IFETCH_BYPASS_EN when the FIFO is empty).
// Backpressure: a request issues only while outstanding + buffered words leave FIFO room; out_ready=0 stalls fetch.
// Optional feature macro: IFETCH_BYPASS_EN (same-cycle response-to-decode bypass when the FIFO is empty).
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic          run_q;
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] osd_q, osd_d, dsc_q, dsc_d, cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [31:0]   aq_q   [DEPTH];
    logic [31:0]   aq_d   [DEPTH];

    logic          grant, pop, keep, push, byp, fifo_empty;
    logic [CW:0]   credits_used;
    logic          unused_redir_lsb;

    // The two low bits of a redirect target are forced to zero, so they are never read.
    assign unused_redir_lsb = ^redirect_pc[1:0];

    // Handshakes, credit check and output mux; a redirect kills issue, bypass and the decode beat.
    always_comb begin
        fifo_empty = (cnt_q == '0);
`ifdef IFETCH_BYPASS_EN
        byp = fifo_empty && (dsc_q == '0) && imem_rvalid && !redirect_valid;
`else
        byp = 1'b0;
`endif
        pop  = !fifo_empty && out_ready && !redirect_valid;
        keep = imem_rvalid && (dsc_q == '0) && !redirect_valid;
        push = keep && !(byp && out_ready);
        // A FIFO slot drained this cycle is free before any response to a new grant can land.
        credits_used = {1'b0, osd_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
        imem_req  = run_q && !redirect_valid && (cnt_q != DEPTH_C[CW-1:0]) && (credits_used < DEPTH_C);
        grant     = imem_req && imem_gnt;
        imem_addr = fpc_q;
        out_valid = !fifo_empty || byp;
        out_pc    = byp ? aq_q[aq_rd_q] : fifo_q[rd_q].pc;
        out_instr = byp ? imem_rdata    : fifo_q[rd_q].instr;
    end

    // Next-state for PC, counters, address queue and FIFO; redirect overrides everything.
    always_comb begin
        fpc_d   = fpc_q;
        osd_d   = osd_q + CW'(grant) - CW'(imem_rvalid);
        dsc_d   = dsc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        aq_rd_d = aq_rd_q;
        aq_wr_d = aq_wr_q;
        fifo_d  = fifo_q;
        aq_d    = aq_q;
        if (redirect_valid) begin
            fpc_d   = {redirect_pc[31:2], 2'b00};
            // Every response still in flight after this edge is stale; dsc already counts a
            // subset of osd, so the new discard count is simply the post-edge outstanding count.
            dsc_d   = osd_q + CW'(grant) - CW'(imem_rvalid);
            cnt_d   = '0;
            rd_d    = wr_q;
            aq_rd_d = aq_wr_q;
        end else begin
            if (grant) begin
                fpc_d         = fpc_q + 32'd4;
                aq_d[aq_wr_q] = fpc_q;
                aq_wr_d       = aq_wr_q + PW'(1);
            end
            if (imem_rvalid) begin
                if (dsc_q != '0) dsc_d   = dsc_q - CW'(1);
                else             aq_rd_d = aq_rd_q + PW'(1);
            end
            if (push) begin
                fifo_d[wr_q] = '{pc: aq_q[aq_rd_q], instr: imem_rdata};
                wr_d         = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State registers; run_q holds off the first request until the cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            fpc_q   <= RESET_PC;
            osd_q   <= '0;
            dsc_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            aq_rd_q <= '0;
            aq_wr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '{pc: RESET_PC, instr: 32'h0};
                aq_q[i]   <= RESET_PC;
            end
        end else begin
            run_q   <= 1'b1;
            fpc_q   <= fpc_d;
            osd_q   <= osd_d;
            dsc_q   <= dsc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            aq_rd_q <= aq_rd_d;
            aq_wr_q <= aq_wr_d;
            fifo_q  <= fifo_d;
            aq_q    <= aq_d;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: drives ifetch_unit with a randomized in-order memory, redirects and decode stalls.
// Expected fetch order is the sequential PC stream restarted at every redirect target.
// A monitor compares each accepted {pc, instr} beat against that stream.
`timescale 1ns/1ps
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef IFETCH_BYPASS_EN
    localparam int EXP_FIRST = 2;
`else
    localparam int EXP_FIRST = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int n_chk = 0;
    int n_fail = 0;

    // stimulus knobs (written only by the control process)
    int gnt_pct, ready_pct, redir_pct, lat_min, lat_extra;
    int rel_cyc = 0;
    int redir_req_n = 0, rv_arm_n = 0;
    logic [31:0] redir_tgt;

    // driver-owned
    int redir_done_n = 0, rv_done_n = 0, pend_rd = 0;
    // tracker-owned
    int cyc = 0;
    logic [31:0] m_fpc = RESET_PC;
    logic [31:0] exp_q[$];
    pend_t       pend_q[$];
    int exp_base = 0, grants = 0, redir_cnt = 0;
    logic [31:0] prev_gaddr = 32'h0;
    bit have_prev = 0, wrap_seen = 0;
    // monitor-owned
    int mon_idx = 0, hs_cnt = 0, first_valid = -1, seen_redir = 0;
    logic [31:0] first_after = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc - rel_cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: presents memory grants/responses, decode ready and redirects each cycle.
    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_gnt  = ($urandom_range(99) < gnt_pct);
            out_ready = ($urandom_range(99) < ready_pct);
            if (rst_n && pend_rd < pend_q.size() && pend_q[pend_rd].due <= cyc) begin
                imem_rvalid = 1;
                imem_rdata  = mem_word(pend_q[pend_rd].addr);
                pend_rd++;
            end else begin
                imem_rvalid = 0;
                imem_rdata  = $urandom;
            end
            redirect_valid = 0;
            redirect_pc    = $urandom;
            if (redir_req_n != redir_done_n) begin
                redirect_valid = 1;
                redirect_pc    = redir_tgt;
                redir_done_n   = redir_req_n;
            end else if (rv_arm_n != rv_done_n && imem_rvalid) begin
                redirect_valid = 1;
                redirect_pc    = redir_tgt;
                rv_done_n      = rv_arm_n;
            end else if (rst_n && $urandom_range(99) < redir_pct) begin
                redirect_valid = 1;
            end
        end
    end

    // Tracker: on every grant the expected pc joins the scoreboard; a redirect restarts the stream.
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid) check("no_req_in_redirect", {31'b0, imem_req}, 32'h0);
            if (imem_req && imem_gnt) begin
                check("grant_addr", imem_addr, m_fpc);
                if (have_prev && prev_gaddr == 32'hFFFF_FFFC && imem_addr == 32'h0) wrap_seen = 1;
                prev_gaddr = imem_addr;
                have_prev  = 1;
                pend_q.push_back('{imem_addr, cyc + 1 + lat_min + $urandom_range(lat_extra)});
                exp_q.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
                grants++;
            end
            if (redirect_valid) begin
                exp_base = exp_q.size();
                m_fpc    = {redirect_pc[31:2], 2'b00};
                redir_cnt++;
            end
        end
    end

    // Monitor: every accepted beat must be the next expected pc with its memory word.
    always @(negedge clk) begin
        if (rst_n && out_valid && first_valid < 0) first_valid = cyc - rel_cyc;
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            hs_cnt++;
            if (mon_idx < exp_base) mon_idx = exp_base;
            if (mon_idx >= exp_q.size()) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h, expected no beat (nothing fetched)", out_pc);
            end else begin
                check("out_pc", out_pc, exp_q[mon_idx]);
                check("out_instr", out_instr, mem_word(exp_q[mon_idx]));
                mon_idx++;
                if (seen_redir != redir_cnt) begin
                    first_after = out_pc;
                    seen_redir  = redir_cnt;
                end
            end
        end
    end

    function automatic int remaining();
        return exp_q.size() - ((mon_idx > exp_base) ? mon_idx : exp_base);
    endfunction

    // Control: directed phases followed by a randomized soak and a drain.
    initial begin
        int hs0, g0;
        logic [31:0] a0;
        bit stable, drained;
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; lat_min = 0; lat_extra = 0;
        redir_tgt = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_imem_req",  {31'b0, imem_req},  32'h0);
        check("rst_imem_addr", imem_addr,          RESET_PC);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_instr", out_instr,          32'h0);
        check("rst_out_pc",    out_pc,             RESET_PC);
        @(posedge clk); #2;
        rst_n = 1;
        rel_cyc = cyc;
        step();
        check("req_cycle0", {31'b0, imem_req}, 32'h0);
        step();
        check("req_cycle1", {31'b0, imem_req}, 32'h1);
        for (int i = 0; i < 20 && first_valid < 0; i++) step();
        check("first_valid_cycle", first_valid, EXP_FIRST);
        hs0 = hs_cnt;
        repeat (10) step();
        check("throughput_10_beats", hs_cnt - hs0, 10);

        // decode stalled: only DEPTH fetches may be issued
        gnt_pct = 0;
        repeat (8) step();
        ready_pct = 0; gnt_pct = 100;
        g0 = grants;
        repeat (10) step();
        check("stall_grants", grants - g0, DEPTH);
        check("stall_req_low", {31'b0, imem_req}, 32'h0);
        check("stall_out_valid", {31'b0, out_valid}, 32'h1);
        ready_pct = 100;
        repeat (6) step();

        // grant withheld: address frozen, pipeline drains
        gnt_pct = 0;
        step();
        a0 = imem_addr;
        stable = 1;
        repeat (5) begin
            step();
            if (imem_addr !== a0) stable = 0;
        end
        check("gnt_hold_addr_stable", {31'b0, stable}, 32'h1);
        check("gnt_hold_out_valid", {31'b0, out_valid}, 32'h0);

        // redirect with two requests in flight
        lat_min = 4; gnt_pct = 100;
        g0 = grants;
        repeat (3) step();
        check("inflight_grants", grants - g0, 2);
        redir_tgt = 32'h0000_1003;
        redir_req_n++;
        lat_min = 0;
        repeat (15) step();
        check("redir_first_pc", first_after, 32'h0000_1000);

        // redirect coinciding with a response
        redir_tgt = 32'h2000_0043;
        rv_arm_n++;
        repeat (15) step();
        check("rv_redirect_fired", rv_done_n, rv_arm_n);
        check("rv_redir_first_pc", first_after, 32'h2000_0040);

        // address wrap
        redir_tgt = 32'hFFFF_FFF8;
        redir_req_n++;
        repeat (12) step();
        check("wrap_first_pc", first_after, 32'hFFFF_FFF8);
        check("wrap_to_zero", {31'b0, wrap_seen}, 32'h1);

        // randomized soak
        gnt_pct = 60; ready_pct = 70; redir_pct = 3; lat_extra = 3;
        repeat (3000) step();

        // drain
        redir_pct = 0; gnt_pct = 0; ready_pct = 100;
        drained = 0;
        for (int i = 0; i < 100 && !drained; i++) begin
            step();
            drained = (pend_rd == pend_q.size()) && (remaining() == 0) && !out_valid;
        end
        check("drain_complete", {31'b0, drained}, 32'h1);
        check("drain_left", remaining(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
